uart_word_tx: RTL
=================

# uart_word_tx

Serializes 16-bit result words onto the board UART TX pin as 8N1 frames. Sits downstream of the RAM readout sequencer: that stage fetches a word from data RAM and presents it here with a valid/ready handshake. This block latches the word, breaks it into bytes and drives `uart_tx`, so the readout logic never deals with bit timing.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `clk` input, 1 bit: single system clock; all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `word_in` input, 16 bits: word to transmit; sampled only on acceptance.
- `word_valid` input, 1 bit: upstream has a word on `word_in`.
- `word_ready` output, 1 bit: block can accept a word. A transfer happens on a rising edge with `word_valid && word_ready`.
- `busy` output, 1 bit: a word is being transmitted.
- `uart_tx` output, 1 bit: serial line; idles high.

## Operation
- FSM states are IDLE, START, DATA, STOP and NEXT.
- IDLE
  - `word_ready` = 1, `busy` = 0, `uart_tx` = 1.
  - On acceptance: latch `word_in` into an internal register, set byte index to 0, load byte 0, go to START.
- START
  - `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA
  - `uart_tx` = current byte bit[bit index], LSB first, for `CLKS_PER_BIT` cycles per bit.
  - After bit 7, go to STOP.
- STOP
  - `uart_tx` = 1 for `CLKS_PER_BIT` cycles, then go to NEXT.
- NEXT (1 cycle, `uart_tx` = 1)
  - If the byte index equals the last index, go to IDLE.
  - Otherwise increment the byte index, load the next byte and go to START.
- Byte sequence in raw mode (see Configuration): 2 bytes, `word[15:8]` then `word[7:0]`.
- Bit counter is 0..`CLKS_PER_BIT`-1, width `$clog2(CLKS_PER_BIT)`; it wraps to 0 on each bit boundary.
- `word_ready` = (state == IDLE); `busy` = !(state == IDLE). Both are registered-state decodes with no combinational path from `word_valid`.
- A change on `word_in` after acceptance has no effect on the frame in progress.
- `word_valid` is ignored while `word_ready` = 0.
- Upstream must hold `word_valid` and `word_in` stable until acceptance.

## Timing
- Reset values: `uart_tx` = 1, `word_ready` = 1, `busy` = 0, state IDLE, all counters 0, word register 0.
- Reset asserted mid-frame: `uart_tx` returns to 1 asynchronously. The partial word is discarded and nothing resumes after release.
- Start bit begins on the cycle after the acceptance edge.
- One byte occupies 10×`CLKS_PER_BIT` + 1 cycles, including the NEXT cycle.
- Raw word, accept to IDLE: 2×(10×`CLKS_PER_BIT` + 1) cycles.
- Back-to-back words with `word_valid` held high:
  - one IDLE cycle (the acceptance cycle) separates the last stop bit from the next start bit;
  - there is no other gap.

## Configuration
- Macro `UART_WORD_HEX_ASCII_EN`.
- Defined: each word is sent as 6 bytes.
  - 4 uppercase ASCII hex digits, MSB nibble first: 0–9 → 0x30–0x39, A–F → 0x41–0x46.
  - Then CR (0x0D) and LF (0x0A).
  - Last byte index = 5.
- Undefined: raw mode, 2 bytes per word, last byte index = 1.
- All state machine and handshake behaviour is identical in both modes; only byte generation and last index differ.

## Structure
- Package `uart_word_pkg`:
  - state enum;
  - `ASCII_CR` and `ASCII_LF` constants;
  - `nibble_to_ascii` function;
  - last-index constants for each mode.
- Sub-module `uart_tx_byte`:
  - owns START/DATA/STOP and the bit and clock counters;
  - load/done handshake with the byte sequencer in `uart_word_tx`.
- `uart_word_tx` keeps the word register, byte index, byte select and IDLE/NEXT.

## Test plan
Benches run with `CLKS_PER_BIT` = 4, sampling `uart_tx` mid-bit.
- Raw mode, send 0xA55A → frames decode to 0xA5 then 0x5A. `word_ready` returns high 2×41 = 82 cycles after acceptance. Start bit low on the cycle after acceptance.
- Hex mode, send 0x1F3C → bytes 0x31, 0x46, 0x33, 0x43, 0x0D, 0x0A; 246 cycles accept to IDLE.
- Hex mode, send 0x0000 then 0xFFFF with `word_valid` held high → "0000\r\n" then "FFFF\r\n". Exactly one high IDLE cycle between the last stop bit and the second start bit.
- Drive `reset` low during bit 3 of byte 0 → `uart_tx` goes to 1 without waiting for a clock edge. After release, `word_ready` = 1 and the line stays high for 200 cycles.
- Accept 0x1234, then change `word_in` to 0xFFFF and toggle `word_valid` during the transfer → output is still 0x12, 0x34 and no second word is accepted until IDLE.
- Hold `word_valid` low for 100 cycles after reset → `uart_tx` = 1, `busy` = 0 and `word_ready` = 1 throughout.

Source files
------------

// File: rtl/uart_word_pkg.sv
// Shared types and constants for the UART word transmitter.
// Hex/ASCII framing is selected with `UART_WORD_HEX_ASCII_EN; these constants serve both modes.
package uart_word_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_NEXT
   } uart_state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam logic [2:0] RAW_LAST_IDX = 3'd1;
   localparam logic [2:0] HEX_LAST_IDX = 3'd5;

   // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F' (0x37 + 10 = 0x41)
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] code;
      if (nib < 4'd10) begin
         code = 8'h30 + {4'h0, nib};
      end else begin
         code = 8'h37 + {4'h0, nib};
      end
      return code;
   endfunction

endpackage

// File: rtl/uart_word_tx_byte.sv
// 8N1 byte serializer: START/DATA/STOP with bit and clock counters.
// Takes a byte on load while idle and pulses done during the final stop-bit cycle.
module uart_tx_byte
   import uart_word_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_load,
   input  logic [7:0] byte_in,
   output logic       byte_done,
   output logic       tx
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_e   state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   // tx is registered from the next-state decision so the pin never glitches
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      byte_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (byte_load) begin
               shift_d   = byte_in;
               clk_cnt_d = '0;
               state_d   = ST_START;
               tx_d      = 1'b0;
            end
         end

         ST_START: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         ST_DATA: begin
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         ST_STOP: begin
            tx_d = 1'b1;
            if (clk_cnt_q == CNT_LAST) begin
               clk_cnt_d = '0;
               state_d   = ST_IDLE;
               byte_done = 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_cnt_d = '0;
            tx_d      = 1'b1;
         end
      endcase
   end

   assign tx = tx_q;

endmodule

// File: rtl/uart_word_tx.sv
// Word-level sequencer: accepts a 16-bit word, splits it into bytes for uart_tx_byte.
// Define UART_WORD_HEX_ASCII_EN to send 4 ASCII hex digits plus CR/LF instead of 2 raw bytes.
module uart_word_tx
   import uart_word_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        busy,
   output logic        uart_tx
);

`ifdef UART_WORD_HEX_ASCII_EN
   localparam logic [2:0] LAST_IDX = HEX_LAST_IDX;

   function automatic logic [7:0] select_byte(input logic [15:0] w, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = nibble_to_ascii(w[15:12]);
         3'd1:    b = nibble_to_ascii(w[11:8]);
         3'd2:    b = nibble_to_ascii(w[7:4]);
         3'd3:    b = nibble_to_ascii(w[3:0]);
         3'd4:    b = ASCII_CR;
         default: b = ASCII_LF;
      endcase
      return b;
   endfunction
`else
   localparam logic [2:0] LAST_IDX = RAW_LAST_IDX;

   function automatic logic [7:0] select_byte(input logic [15:0] w, input logic [2:0] idx);
      logic [7:0] b;
      if (idx == 3'd0) begin
         b = w[15:8];
      end else begin
         b = w[7:0];
      end
      return b;
   endfunction
`endif

   uart_state_e state_q, state_d;
   logic [15:0] word_q, word_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic        byte_load;
   logic [7:0]  load_byte;
   logic        byte_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         byte_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   // ST_DATA here means "a byte is in flight in the serializer";
   // byte 0 comes straight from word_in so its start bit begins right after acceptance
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      byte_load  = 1'b0;
      load_byte  = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (word_valid) begin
               word_d     = word_in;
               byte_idx_d = 3'd0;
               byte_load  = 1'b1;
               load_byte  = select_byte(word_in, 3'd0);
               state_d    = ST_DATA;
            end
         end

         ST_DATA: begin
            if (byte_done) begin
               state_d = ST_NEXT;
            end
         end

         ST_NEXT: begin
            if (byte_idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               byte_idx_d = byte_idx_q + 3'd1;
               byte_load  = 1'b1;
               load_byte  = select_byte(word_q, byte_idx_q + 3'd1);
               state_d    = ST_DATA;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk      (clk),
      .reset    (reset),
      .byte_load(byte_load),
      .byte_in  (load_byte),
      .byte_done(byte_done),
      .tx       (uart_tx)
   );

   assign word_ready = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);

endmodule
